// File: rtl/imm_extend_pipe_if.sv
// Upstream/downstream bundle for the pipelined immediate extender.
// Upstream fields are prefixed in_, downstream fields out_.
interface imm_extend_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       imm_src;
    logic [31:0]      inst;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm_ext;
    logic [TAG_W-1:0] out_tag;
    logic             illegal;

    modport master (
        output in_valid, imm_src, inst, in_tag, out_ready,
        input  in_ready, out_valid, imm_ext, out_tag, illegal
    );

    modport slave (
        input  in_valid, imm_src, inst, in_tag, out_ready,
        output in_ready, out_valid, imm_ext, out_tag, illegal
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined RISC-V immediate extender: combinational decode in front of stage 0,
// then STAGES valid/ready register stages carrying {imm, tag, illegal}.
module imm_extend_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    imm_extend_pipe_if.slave bus
);
    logic [XLEN-1:0]   ext;
    logic              ext_illegal;
    logic signed [31:0] sx;

    // Unlisted or unknown selects fall through to the default arm.
    always_comb begin
        ext         = '0;
        ext_illegal = 1'b0;
        sx          = '0;
        case (bus.imm_src)
            4'b0000, 4'b0001, 4'b0110: begin
                sx  = 32'($signed(bus.inst[31:20]));
                ext = XLEN'(sx);
            end
            4'b0010: begin
                if (XLEN == 64) ext = XLEN'(bus.inst[25:20]);
                else            ext = XLEN'(bus.inst[24:20]);
            end
            4'b0011: begin
                sx  = 32'($signed({bus.inst[31:25], bus.inst[11:7]}));
                ext = XLEN'(sx);
            end
            4'b0100: begin
                sx  = $signed({bus.inst[31:12], 12'b0});
                ext = XLEN'(sx);
            end
            4'b0101: begin
                sx  = 32'($signed({bus.inst[31], bus.inst[7], bus.inst[30:25],
                                   bus.inst[11:8], 1'b0}));
                ext = XLEN'(sx);
            end
            4'b0111: begin
                sx  = 32'($signed({bus.inst[31], bus.inst[19:12], bus.inst[20],
                                   bus.inst[30:21], 1'b0}));
                ext = XLEN'(sx);
            end
            4'b1000: ext = XLEN'(bus.inst[19:15]);
            default: begin
                ext         = '0;
                ext_illegal = 1'b1;
            end
        endcase
    end

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] ill_q;
    logic [XLEN-1:0]   ext_q [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [STAGES:0]   ready;

    // An empty stage is always ready, so bubbles collapse under back-pressure.
    always_comb begin
        ready         = '0;
        ready[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ready[k] = !valid_q[k] || ready[k+1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            ill_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                ext_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            if (ready[0]) begin
                valid_q[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    ext_q[0] <= ext;
                    tag_q[0] <= bus.in_tag;
                    ill_q[0] <= ext_illegal;
                end
            end
            // Payload only moves with a valid entry to keep outputs quiet.
            for (int k = 1; k < STAGES; k++) begin
                if (ready[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) begin
                        ext_q[k] <= ext_q[k-1];
                        tag_q[k] <= tag_q[k-1];
                        ill_q[k] <= ill_q[k-1];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = ready[0];
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.imm_ext   = ext_q[STAGES-1];
    assign bus.out_tag   = tag_q[STAGES-1];
    assign bus.illegal   = ill_q[STAGES-1];
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: a 32-bit/2-stage and a 64-bit/3-stage instance.
module tb_imm_extend_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush32 = 1'b0;
    logic flush64 = 1'b0;
    always #5 clk = ~clk;

    imm_extend_pipe_if #(.XLEN(32), .TAG_W(32)) a ();
    imm_extend_pipe_if #(.XLEN(64), .TAG_W(32)) b ();

    imm_extend_pipe #(.XLEN(32), .STAGES(2), .TAG_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush32), .bus(a));
    imm_extend_pipe #(.XLEN(64), .STAGES(3), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush64), .bus(b));

    typedef struct packed {
        logic [63:0] ext;
        logic [31:0] tag;
        logic        ill;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_out32 = 0;
    int first_out = -1;
    int last_out = -1;

    always @(posedge clk) cyc++;

    function automatic logic [64:0] ref_ext(input logic [3:0] src, input logic [31:0] inst,
                                            input int xlen);
        logic [63:0] v;
        logic        ill;
        ill = 1'b0;
        case (src)
            4'd0, 4'd1, 4'd6: v = {{52{inst[31]}}, inst[31:20]};
            4'd2: v = (xlen == 64) ? {58'b0, inst[25:20]} : {59'b0, inst[24:20]};
            4'd3: v = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            4'd4: v = {{32{inst[31]}}, inst[31:12], 12'h000};
            4'd5: v = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            4'd7: v = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            4'd8: v = {59'b0, inst[19:15]};
            default: begin
                v   = 64'd0;
                ill = 1'b1;
            end
        endcase
        if (xlen == 32) v[63:32] = 32'd0;
        return {ill, v};
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Output monitors: every delivered entry is popped and compared.
    exp_t e32, e64;
    bit   had32, had64;
    always @(negedge clk) begin
        if (!rst && a.out_valid && a.out_ready) begin
            had32 = (q32.size() > 0);
            e32   = had32 ? q32.pop_front() : '0;
            checks++;
            assert (had32 && a.imm_ext === e32.ext[31:0] && a.out_tag === e32.tag
                    && a.illegal === e32.ill)
            else begin
                errors++;
                $error("FAIL sb32: observed ext=%0h tag=%0h ill=%0b expected ext=%0h tag=%0h ill=%0b queued=%0b",
                       a.imm_ext, a.out_tag, a.illegal, e32.ext[31:0], e32.tag, e32.ill, had32);
            end
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            n_out32++;
        end
        if (!rst && b.out_valid && b.out_ready) begin
            had64 = (q64.size() > 0);
            e64   = had64 ? q64.pop_front() : '0;
            checks++;
            assert (had64 && b.imm_ext === e64.ext && b.out_tag === e64.tag
                    && b.illegal === e64.ill)
            else begin
                errors++;
                $error("FAIL sb64: observed ext=%0h tag=%0h ill=%0b expected ext=%0h tag=%0h ill=%0b queued=%0b",
                       b.imm_ext, b.out_tag, b.illegal, e64.ext, e64.tag, e64.ill, had64);
            end
        end
    end

    task automatic send32(input logic [3:0] src, input logic [31:0] inst,
                          input logic [31:0] tag, input bit track);
        int n;
        logic [64:0] r;
        n = 0;
        a.in_valid = 1'b1;
        a.imm_src  = src;
        a.inst     = inst;
        a.in_tag   = tag;
        @(negedge clk);
        while (!a.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("send32_accept", 64'(a.in_ready), 64'd1);
        if (track) begin
            r = ref_ext(src, inst, 32);
            q32.push_back({r[63:0], tag, r[64]});
        end
        @(posedge clk);
        #1 a.in_valid = 1'b0;
    endtask

    task automatic send64(input logic [3:0] src, input logic [31:0] inst,
                          input logic [31:0] tag);
        int n;
        logic [64:0] r;
        n = 0;
        b.in_valid = 1'b1;
        b.imm_src  = src;
        b.inst     = inst;
        b.in_tag   = tag;
        @(negedge clk);
        while (!b.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("send64_accept", 64'(b.in_ready), 64'd1);
        r = ref_ext(src, inst, 64);
        q64.push_back({r[63:0], tag, r[64]});
        @(posedge clk);
        #1 b.in_valid = 1'b0;
    endtask

    task automatic wait_out32();
        int n;
        n = 0;
        while (!a.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("out32_valid", 64'(a.out_valid), 64'd1);
    endtask

    task automatic wait_out64();
        int n;
        n = 0;
        while (!b.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("out64_valid", 64'(b.out_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [31:0] hold_ext, hold_tag;
    logic [64:0] r3;

    initial begin
        a.in_valid = 1'b0; a.imm_src = '0; a.inst = '0; a.in_tag = '0; a.out_ready = 1'b1;
        b.in_valid = 1'b0; b.imm_src = '0; b.inst = '0; b.in_tag = '0; b.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 64'(a.out_valid), 64'd0);
        chk("rst_in_ready",  64'(a.in_ready),  64'd1);
        chk("rst_imm_ext",   64'(a.imm_ext),   64'd0);
        chk("rst_tag",       64'(a.out_tag),   64'd0);
        chk("rst_illegal",   64'(a.illegal),   64'd0);

        // Exact latency on the first entry, then two more spot values.
        @(posedge clk);
        #1 send32(4'b0101, 32'hF0F0F0F0, 32'h100, 1'b1);
        @(negedge clk);
        chk("lat_not_yet", 64'(a.out_valid), 64'd0);
        @(negedge clk);
        chk("lat_valid", 64'(a.out_valid), 64'd1);
        chk("b_imm", 64'(a.imm_ext), 64'hFFFFFF00);

        @(posedge clk);
        #1 send32(4'b0111, 32'hF0F0F0F0, 32'h101, 1'b1);
        @(negedge clk);
        wait_out32();
        chk("j_imm", 64'(a.imm_ext), 64'hFFF0FF0E);

        @(posedge clk);
        #1 send32(4'b0110, 32'h80100000, 32'h102, 1'b1);
        @(negedge clk);
        wait_out32();
        chk("jalr_imm", 64'(a.imm_ext), 64'hFFFFF801);

        @(posedge clk);
        #1 send32(4'b1011, 32'hFFFFFFFF, 32'h103, 1'b1);
        @(negedge clk);
        wait_out32();
        chk("illegal_imm", 64'(a.imm_ext), 64'd0);
        chk("illegal_flag", 64'(a.illegal), 64'd1);

        // Streaming: 8 back-to-back entries must appear on 8 consecutive cycles.
        @(posedge clk);
        #1;
        n_out32 = 0;
        first_out = -1;
        last_out = -1;
        for (int i = 0; i < 8; i++) send32(4'(i), $urandom, 32'(i), 1'b1);
        repeat (6) @(negedge clk);
        chk("stream_count", 64'(n_out32), 64'd8);
        chk("stream_contig", 64'(last_out - first_out), 64'd7);

        // Back-pressure: fill both stages, stall 5 cycles with a third entry waiting.
        @(posedge clk);
        #1 a.out_ready = 1'b0;
        send32(4'b0011, 32'hFE0FF0A3, 32'h20, 1'b1);
        send32(4'b0100, 32'h12345678, 32'h21, 1'b1);
        @(negedge clk);
        chk("bp_full_ready", 64'(a.in_ready), 64'd0);
        chk("bp_out_valid", 64'(a.out_valid), 64'd1);
        hold_ext = a.imm_ext;
        hold_tag = a.out_tag;
        @(posedge clk);
        #1;
        a.in_valid = 1'b1; a.imm_src = 4'b1000; a.inst = 32'h000A8000; a.in_tag = 32'h22;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_ext", 64'(a.imm_ext), 64'(hold_ext));
            chk("bp_hold_tag", 64'(a.out_tag), 64'(hold_tag));
            chk("bp_in_ready", 64'(a.in_ready), 64'd0);
        end
        r3 = ref_ext(4'b1000, 32'h000A8000, 32);
        q32.push_back({r3[63:0], 32'h22, r3[64]});
        @(posedge clk);
        #1 a.out_ready = 1'b1;
        @(posedge clk);
        #1 a.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("bp_drained", 64'(q32.size()), 64'd0);

        // 64-bit, 3-stage instance.
        @(posedge clk);
        #1 send64(4'b0100, 32'h80000000, 32'h40);
        @(negedge clk);
        wait_out64();
        chk("u64_imm", b.imm_ext, 64'hFFFFFFFF80000000);
        @(posedge clk);
        #1 send64(4'b0010, 32'hFFFFFFFF, 32'h41);
        @(negedge clk);
        wait_out64();
        chk("shamt64_imm", b.imm_ext, 64'h3F);
        @(posedge clk);
        #1 send64(4'b1000, 32'h000A8000, 32'h42);
        @(negedge clk);
        wait_out64();
        chk("zimm64_imm", b.imm_ext, 64'h15);

        // Flush with two entries in flight and a third offered in the flush cycle.
        @(posedge clk);
        #1 a.out_ready = 1'b0;
        send32(4'b0000, 32'h7FF00000, 32'h30, 1'b0);
        send32(4'b0001, 32'h80000000, 32'h31, 1'b0);
        a.in_valid = 1'b1; a.imm_src = 4'b0001; a.in_tag = 32'h32;
        flush32 = 1'b1;
        @(posedge clk);
        #1;
        flush32 = 1'b0;
        a.in_valid = 1'b0;
        a.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flush_no_valid", 64'(a.out_valid), 64'd0);
        end

        // Reset mid-stream: everything in flight is dropped and outputs return to 0.
        @(posedge clk);
        #1 a.out_ready = 1'b0;
        send32(4'b0101, 32'hF0F0F0F0, 32'h50, 1'b0);
        send32(4'b0011, 32'hFFFFFFFF, 32'h51, 1'b0);
        a.in_valid = 1'b1; a.in_tag = 32'h52;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        a.in_valid = 1'b0;
        a.out_ready = 1'b1;
        @(negedge clk);
        chk("rst2_out_valid", 64'(a.out_valid), 64'd0);
        chk("rst2_imm_ext",   64'(a.imm_ext),   64'd0);
        chk("rst2_tag",       64'(a.out_tag),   64'd0);
        chk("rst2_illegal",   64'(a.illegal),   64'd0);
        chk("rst2_in_ready",  64'(a.in_ready),  64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst2_no_valid", 64'(a.out_valid), 64'd0);
        end

        chk("q32_empty", 64'(q32.size()), 64'd0);
        chk("q64_empty", 64'(q64.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate extender.
- Accepts a raw RV instruction word plus immediate-format select through a valid/ready handshake.
- Produces the XLEN-wide extended immediate after STAGES register stages, along with a sideband tag and an illegal-format flag.
- Sits between the fetch/decode boundary and the execute operand mux; supports stall back-pressure and pipeline flush.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- STAGES, 2, number of register stages; legal range 1..4.
- TAG_W, 32, width of the pass-through sideband (PC or rd/uop tag).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- i_flush  input  1  synchronous squash of all in-flight entries
- i_valid  input  1  upstream entry valid
- o_ready  output  1  block can accept an entry this cycle
- i_immSrc  input  4  immediate format select
- i_inst  input  32  raw instruction word
- i_tag  input  TAG_W  sideband, carried unchanged
- o_valid  output  1  output entry valid
- i_ready  input  1  downstream accepts the entry
- o_immExt  output  XLEN  extended immediate
- o_tag  output  TAG_W  sideband of the output entry
- o_illegal  output  1  entry used an unsupported i_immSrc

Behaviour:
- Extension is combinational in front of stage 0. Stages 1..STAGES-1 only carry {immExt, tag, illegal}. "sx" means sign-extend to XLEN from inst[31]; "zx" means zero-extend.
- i_immSrc decode:
  - 0000 I-load: sx(inst[31:20])
  - 0001 I-alu: sx(inst[31:20])
  - 0010 shamt: zx(inst[24:20]) when XLEN=32; zx(inst[25:20]) when XLEN=64
  - 0011 S: sx({inst[31:25],inst[11:7]})
  - 0100 U: sx({inst[31:12],12'b0}); upper bits are all inst[31] when XLEN=64
  - 0101 B: sx({inst[31],inst[7],inst[30:25],inst[11:8],1'b0})
  - 0110 I-jalr: sx(inst[31:20])
  - 0111 J: sx({inst[31],inst[19:12],inst[20],inst[30:21],1'b0})
  - 1000 CSR zimm: zx(inst[19:15])
  - 1001..1111: o_immExt=0, o_illegal=1. No X propagation. Any X/Z on i_immSrc is also treated as illegal.
- Handshake:
  - Transfer at the input when i_valid && o_ready; at the output when o_valid && i_ready.
  - i_valid must not depend on o_ready.
  - Per stage k: ready[k] = !valid[k] || ready[k+1], with ready[STAGES] = i_ready. o_ready = ready[0], combinational from i_ready.
  - A stage loads when ready[k] is high. Its valid bit becomes the previous stage's valid bit (the input transfer for stage 0).
  - Full throughput of 1 entry/cycle. Latency is exactly STAGES cycles when not stalled: an entry accepted at edge N is presented on o_valid after edge N+STAGES-1, i.e. visible in cycle N+STAGES.
- Stall: while o_valid && !i_ready, o_immExt, o_tag and o_illegal hold stable, and no entry is lost or duplicated. Bubbles collapse: an empty stage accepts even while downstream is stalled.
- Reset: all valid bits 0, all data registers 0. After reset: o_valid=0, o_immExt=0, o_tag=0, o_illegal=0, o_ready=1.
- Reset mid-operation: every in-flight entry is discarded at that edge.
- Flush: i_flush clears all valid bits at the next edge. Data registers are not cleared. An input presented in the same cycle as i_flush is dropped, even if o_ready=1. If an output handshake occurs in the flush cycle, it still counts as delivered.
- rst has priority over i_flush. i_flush has priority over load.
- Stage payload registers only update on load. This holds power and keeps outputs stable.

Test Plan:
- Defaults, after reset: o_valid=0, o_ready=1, o_immExt=0. Send inst=0xF0F0F0F0 with src 0101 → o_immExt=0xFFFFFF00 exactly 2 cycles later. Then src 0111 on the same inst → 0xFFF0FF0E. Then src 0110 with inst=0x80100000 → 0xFFFFF801.
- Streaming: 8 back-to-back entries, tags 0..7, i_ready=1 → 8 consecutive o_valid cycles, tags in order, no gaps.
- Back-pressure: fill the pipe, then drop i_ready low for 5 cycles → o_ready=0 once both stages are full; output holds; all entries are delivered in order once i_ready=1.
- XLEN=64, STAGES=3:
  - src 0100, inst=0x80000000 → 0xFFFFFFFF80000000
  - src 0010, inst=0xFFFFFFFF → 0x3F
  - src 1000, inst bits[19:15]=10101 → 0x15
- Illegal/flush:
  - src 1011 → o_immExt=0, o_illegal=1.
  - Assert i_flush with 2 entries in flight plus an input offered → no o_valid in the following cycles.
  - Assert rst mid-stream → same result, with all outputs 0.
